ahb_master_arbiter: RTL
=======================

Name: ahb_master_arbiter

Overview:
- Upstream companion of the four-port AHB master mux. Generates the mux's HMSEL select so the mux is self-arbitrating instead of externally steered.
- Observes every master's address-phase request and burst/lock controls, plus the mux's current address-phase owner (HMASTER).
- Grants round-robin at legal transfer boundaries and never splits a fixed-length burst, an INCR burst or a locked sequence.

Parameters:
ENABLE_MASK, 4'b1111, bit i=1 means master i exists; disabled masters never win a grant.
NUM_BEAT_W, 4, width of the burst beat counter (must hold 15).

Ports:
HCLK  in  1  bus clock
HRESETn  in  1  asynchronous active-low reset
HREADY  in  1  slave HREADY (mux MOUT_HREADY); arbitration state advances only when high
HMASTER  in  2  current address-phase owner from the mux
M0_HTRANS..M3_HTRANS  in  2 each  master transfer type
M0_HBURST..M3_HBURST  in  3 each  master burst type
M0_HMASTLOCK..M3_HMASTLOCK  in  1 each  master lock request
HMSEL  out  2  select to the mux for the next address phase
HGRANT  out  4  one-hot decode of HMSEL
BURST_ACTIVE  out  1  registered; owner is mid-burst or locked, so no switch is allowed
PROTO_ERR  out  1  registered one-cycle pulse on an owner protocol violation

Behaviour:
- Reset (HRESETn low, async):
  - beat_cnt=0, incr_hold=0, BURST_ACTIVE=0, PROTO_ERR=0.
  - HMSEL follows combinational logic. With the mux reset, HMASTER=0, so HMSEL=0 and HGRANT=4'b0001 while no master requests.
- Definitions:
  - Owner o = HMASTER. T, B and L are owner o's HTRANS, HBURST and HMASTLOCK.
  - req[i] = ENABLE_MASK[i] & (Mi_HTRANS==NONSEQ) & (i != o).
  - len(B): INCR4/WRAP4=4, INCR8/WRAP8=8, INCR16/WRAP16=16.
- Hold term (combinational from registered state plus the owner's current controls):
  - hold = BURST_ACTIVE | L | (T==BUSY) | (T==SEQ) | (T==NONSEQ & B!=SINGLE).
  - A SEQ final beat of a fixed burst (beat_cnt==1) clears hold for that beat only, so the switch occurs as that beat is accepted.
- HMSEL, combinational:
  - If hold, HMSEL=o.
  - Otherwise, the first i with req[i], searching o+1, o+2, o+3 modulo 4.
  - If no req, HMSEL=o (park on current owner).
  - The mux samples HMSEL only on HREADY high; HMSEL may glitch while HREADY is low.
- State update, only on posedge HCLK with HREADY=1 (all state held when HREADY=0):
  - NONSEQ with fixed B: beat_cnt <= len-1; BURST_ACTIVE <= 1.
  - NONSEQ with B=INCR: incr_hold <= 1; BURST_ACTIVE <= 1.
  - NONSEQ with B=SINGLE: beat_cnt <= 0; incr_hold <= 0; BURST_ACTIVE <= L.
  - SEQ: if beat_cnt>0, beat_cnt <= beat_cnt-1 and BURST_ACTIVE <= (beat_cnt-1 != 0) | L. If incr_hold, stay held.
  - IDLE: incr_hold <= 0; beat_cnt <= 0; BURST_ACTIVE <= L.
  - BUSY: no counter change.
- INCR bursts release only when the owner presents IDLE, or a NONSEQ SINGLE, at an HREADY edge. The switch happens at that edge.
- Locked sequences: L=1 holds ownership through any HTRANS. Release occurs at the first HREADY edge with L=0 and no burst active.
- PROTO_ERR is set for one cycle at an HREADY edge if any of these occur:
  - Owner presents SEQ or BUSY with beat_cnt==0 and incr_hold==0.
  - Owner presents NONSEQ while beat_cnt>0.
  - HMASTER points at a master disabled in ENABLE_MASK.
  - On error, beat_cnt and incr_hold clear.
- Simultaneous requests are resolved purely by the rotating search order. Worst-case wait is 3 grant turns, each bounded by the owner's burst length (INCR and locked tenures excepted).
- Latency: a new requester is granted in the same cycle the owner's final beat is accepted (zero added cycles over the mux's own register).

Test Plan:
- Reset, all masters IDLE: HMSEL=0, HGRANT=0001, BURST_ACTIVE=0, PROTO_ERR=0.
- Owner 0 issues NONSEQ INCR4 while M2 is at NONSEQ SINGLE: HMSEL stays 0 for 4 accepted beats (beat_cnt 3,2,1). HMSEL=2 on the 4th beat's HREADY edge.
- Owner 1 idle; M0, M2 and M3 all request: grants go 2, then 3, then 0 on successive single transfers (round-robin from 1).
- Owner 3 INCR with HREADY low for 5 cycles mid-burst: no state change and HMSEL=3 throughout. Release occurs on IDLE.
- Owner 0 HMASTLOCK=1 across two singles with M1 requesting: HMSEL=0 until the edge where L=0, then HMSEL=1.
- Owner presents SEQ with no burst open: PROTO_ERR pulses 1 cycle. Also assert HRESETn low mid-INCR8: beat_cnt=0 and BURST_ACTIVE=0 immediately.

Source files
------------

// File: rtl/ahb_master_arbiter.sv
// Round-robin HMSEL generator for the four-port AHB master mux.
// Holds the current owner through fixed bursts, INCR bursts and locked sequences.
module ahb_master_arbiter #(
   parameter logic [3:0] ENABLE_MASK = 4'b1111,
   parameter int         NUM_BEAT_W  = 4
) (
   input  logic       HCLK,
   input  logic       HRESETn,
   input  logic       HREADY,
   input  logic [1:0] HMASTER,
   input  logic [1:0] M0_HTRANS,
   input  logic [1:0] M1_HTRANS,
   input  logic [1:0] M2_HTRANS,
   input  logic [1:0] M3_HTRANS,
   input  logic [2:0] M0_HBURST,
   input  logic [2:0] M1_HBURST,
   input  logic [2:0] M2_HBURST,
   input  logic [2:0] M3_HBURST,
   input  logic       M0_HMASTLOCK,
   input  logic       M1_HMASTLOCK,
   input  logic       M2_HMASTLOCK,
   input  logic       M3_HMASTLOCK,
   output logic [1:0] HMSEL,
   output logic [3:0] HGRANT,
   output logic       BURST_ACTIVE,
   output logic       PROTO_ERR
);

   localparam logic [1:0] TR_IDLE   = 2'b00;
   localparam logic [1:0] TR_BUSY   = 2'b01;
   localparam logic [1:0] TR_NONSEQ = 2'b10;
   localparam logic [1:0] TR_SEQ    = 2'b11;
   localparam logic [2:0] BU_SINGLE = 3'b000;
   localparam logic [2:0] BU_INCR   = 3'b001;

   function automatic logic [NUM_BEAT_W-1:0] burst_len_m1(input logic [2:0] b);
      case (b)
         3'b010, 3'b011: burst_len_m1 = NUM_BEAT_W'(3);
         3'b100, 3'b101: burst_len_m1 = NUM_BEAT_W'(7);
         3'b110, 3'b111: burst_len_m1 = NUM_BEAT_W'(15);
         default:        burst_len_m1 = NUM_BEAT_W'(0);
      endcase
   endfunction

   logic [NUM_BEAT_W-1:0] beat_cnt_q, beat_cnt_d;
   logic                  incr_hold_q, incr_hold_d;
   logic                  burst_active_q, burst_active_d;
   logic                  proto_err_q, proto_err_d;

   logic [7:0] trans_vec_s;
   logic [1:0] own_trans_s;
   logic [2:0] own_burst_s;
   logic       own_lock_s;
   logic [3:0] req_s;
   logic       final_beat_s, release_s, hold_s, err_s, found_s;
   logic [1:0] cand_s;

   assign trans_vec_s  = {M3_HTRANS, M2_HTRANS, M1_HTRANS, M0_HTRANS};
   assign BURST_ACTIVE = burst_active_q;
   assign PROTO_ERR    = proto_err_q;

   // Select the owner's controls and build the request vector.
   always_comb begin
      case (HMASTER)
         2'd0: begin own_trans_s = M0_HTRANS; own_burst_s = M0_HBURST; own_lock_s = M0_HMASTLOCK; end
         2'd1: begin own_trans_s = M1_HTRANS; own_burst_s = M1_HBURST; own_lock_s = M1_HMASTLOCK; end
         2'd2: begin own_trans_s = M2_HTRANS; own_burst_s = M2_HBURST; own_lock_s = M2_HMASTLOCK; end
         default: begin own_trans_s = M3_HTRANS; own_burst_s = M3_HBURST; own_lock_s = M3_HMASTLOCK; end
      endcase
      req_s = 4'b0000;
      for (int i = 0; i < 4; i++) begin
         req_s[i] = ENABLE_MASK[i] & (trans_vec_s[2*i +: 2] == TR_NONSEQ) & (HMASTER != 2'(i));
      end
   end

   // The final SEQ beat of a fixed burst, IDLE and NONSEQ SINGLE all let the
   // owner go at the very edge they are accepted.
   always_comb begin
      final_beat_s = (own_trans_s == TR_SEQ) & (beat_cnt_q == NUM_BEAT_W'(1)) & ~incr_hold_q;
      release_s    = (own_trans_s == TR_IDLE) | final_beat_s |
                     ((own_trans_s == TR_NONSEQ) & (own_burst_s == BU_SINGLE));
      hold_s       = own_lock_s | (own_trans_s == TR_BUSY) |
                     ((own_trans_s == TR_SEQ) & ~final_beat_s) |
                     ((own_trans_s == TR_NONSEQ) & (own_burst_s != BU_SINGLE)) |
                     (burst_active_q & ~release_s);
      err_s        = (((own_trans_s == TR_SEQ) | (own_trans_s == TR_BUSY)) &
                      (beat_cnt_q == NUM_BEAT_W'(0)) & ~incr_hold_q) |
                     ((own_trans_s == TR_NONSEQ) & (beat_cnt_q != NUM_BEAT_W'(0))) |
                     ~ENABLE_MASK[HMASTER];
   end

   // Rotating search from owner+1; parks on the owner when nobody asks.
   always_comb begin
      HMSEL   = HMASTER;
      found_s = 1'b0;
      cand_s  = HMASTER;
      if (!hold_s) begin
         for (int k = 1; k < 4; k++) begin
            cand_s = HMASTER + 2'(k);
            if (!found_s && req_s[cand_s]) begin
               HMSEL   = cand_s;
               found_s = 1'b1;
            end else begin
               found_s = found_s;
            end
         end
      end else begin
         HMSEL = HMASTER;
      end
      HGRANT = 4'b0001 << HMSEL;
   end

   // Burst tracking next state; frozen while HREADY is low.
   always_comb begin
      beat_cnt_d     = beat_cnt_q;
      incr_hold_d    = incr_hold_q;
      burst_active_d = burst_active_q;
      proto_err_d    = 1'b0;
      if (HREADY) begin
         case (own_trans_s)
            TR_NONSEQ: begin
               if (own_burst_s[2] | own_burst_s[1]) begin
                  beat_cnt_d     = burst_len_m1(own_burst_s);
                  incr_hold_d    = 1'b0;
                  burst_active_d = 1'b1;
               end else if (own_burst_s == BU_INCR) begin
                  beat_cnt_d     = NUM_BEAT_W'(0);
                  incr_hold_d    = 1'b1;
                  burst_active_d = 1'b1;
               end else begin
                  beat_cnt_d     = NUM_BEAT_W'(0);
                  incr_hold_d    = 1'b0;
                  burst_active_d = own_lock_s;
               end
            end
            TR_SEQ: begin
               if (beat_cnt_q != NUM_BEAT_W'(0)) begin
                  beat_cnt_d     = beat_cnt_q - NUM_BEAT_W'(1);
                  burst_active_d = (beat_cnt_q != NUM_BEAT_W'(1)) | own_lock_s;
               end else begin
                  burst_active_d = incr_hold_q | own_lock_s;
               end
            end
            TR_IDLE: begin
               beat_cnt_d     = NUM_BEAT_W'(0);
               incr_hold_d    = 1'b0;
               burst_active_d = own_lock_s;
            end
            default: begin
               beat_cnt_d = beat_cnt_q;
            end
         endcase
         if (err_s) begin
            beat_cnt_d     = NUM_BEAT_W'(0);
            incr_hold_d    = 1'b0;
            burst_active_d = own_lock_s;
            proto_err_d    = 1'b1;
         end else begin
            proto_err_d = 1'b0;
         end
      end else begin
         proto_err_d = 1'b0;
      end
   end

   // State registers.
   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         beat_cnt_q     <= NUM_BEAT_W'(0);
         incr_hold_q    <= 1'b0;
         burst_active_q <= 1'b0;
         proto_err_q    <= 1'b0;
      end else begin
         beat_cnt_q     <= beat_cnt_d;
         incr_hold_q    <= incr_hold_d;
         burst_active_q <= burst_active_d;
         proto_err_q    <= proto_err_d;
      end
   end

endmodule
